// File: rtl/cpu_types_pkg.sv
// Shared CPU types: decoder fields, ALU operations and the multicycle controller's
// state and mux-select encodings.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PC4    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JREG   = 2'd3
    } pcsel_t;

    typedef enum logic [1:0] {
        SRC_REG      = 2'd0,
        SRC_IMM_SEXT = 2'd1,
        SRC_IMM_ZEXT = 2'd2,
        SRC_SHAMT    = 2'd3
    } alusrc_t;

    typedef enum logic [1:0] {
        DST_RD = 2'd0,
        DST_RT = 2'd1,
        DST_RA = 2'd2
    } regdst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_LUI = 2'd3
    } wbsel_t;

    function automatic logic is_mem_op(opcode_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder/datapath-facing bundle of the multicycle controller; master is the
// controller side, slave is the datapath/decoder side.
interface multicycle_ctrl_if;
    import cpu_types_pkg::*;

    opcode_t     opcode;
    funct_t      funct;
    logic        zero;
    logic        ihit;
    logic        dhit;
    logic        iREN;
    logic        dREN;
    logic        dWEN;
    logic        ir_en;
    logic        pc_en;
    pcsel_t      pc_sel;
    alusrc_t     alu_src_b;
    aluop_t      alu_op;
    logic        reg_wen;
    regdst_t     reg_dst;
    wbsel_t      wb_sel;
    logic        halt;
    ctrl_state_t state;

    modport master (
        input  opcode, funct, zero, ihit, dhit,
        output iREN, dREN, dWEN, ir_en, pc_en, pc_sel, alu_src_b, alu_op,
               reg_wen, reg_dst, wb_sel, halt, state
    );

    modport slave (
        output opcode, funct, zero, ihit, dhit,
        input  iREN, dREN, dWEN, ir_en, pc_en, pc_sel, alu_src_b, alu_op,
               reg_wen, reg_dst, wb_sel, halt, state
    );

endinterface

// File: rtl/ctrl_alu_map.sv
// Combinational opcode/funct decode into ALU operation, B-operand source and an
// illegal-instruction flag.
module ctrl_alu_map
    import cpu_types_pkg::*;
(
    input  opcode_t opcode,
    input  funct_t  funct,
    output aluop_t  alu_op,
    output alusrc_t alu_src_b,
    output logic    illegal
);

    // LUI result comes from the writeback mux, so its ALU setting is a don't-care.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = SRC_REG;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL:          begin alu_op = ALU_SLL; alu_src_b = SRC_SHAMT; end
                    FN_SRL:          begin alu_op = ALU_SRL; alu_src_b = SRC_SHAMT; end
                    FN_JR:           alu_op = ALU_ADD;
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_J, OP_JAL, OP_HALT:    alu_op = ALU_ADD;
            OP_BEQ, OP_BNE:           alu_op = ALU_SUB;
            OP_ADDIU, OP_LW, OP_SW:   begin alu_op = ALU_ADD;  alu_src_b = SRC_IMM_SEXT; end
            OP_SLTI:                  begin alu_op = ALU_SLT;  alu_src_b = SRC_IMM_SEXT; end
            OP_SLTIU:                 begin alu_op = ALU_SLTU; alu_src_b = SRC_IMM_SEXT; end
            OP_ANDI:                  begin alu_op = ALU_AND;  alu_src_b = SRC_IMM_ZEXT; end
            OP_ORI:                   begin alu_op = ALU_OR;   alu_src_b = SRC_IMM_ZEXT; end
            OP_XORI:                  begin alu_op = ALU_XOR;  alu_src_b = SRC_IMM_ZEXT; end
            OP_LUI:                   begin alu_op = ALU_OR;   alu_src_b = SRC_IMM_ZEXT; end
            default:                  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing fetch, decode, execute, memory and writeback
// over the shared datapath; only the state and the sticky halt flag are registered.
module multicycle_ctrl
    import cpu_types_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic               CLK,
    input logic               RST,
    multicycle_ctrl_if.master bus
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALT   = ST_HALT;

    logic [2:0] state_q;
    logic [2:0] next_state;
    logic       halt_q;
    aluop_t     map_alu_op;
    alusrc_t    map_src;
    logic       map_illegal;

    ctrl_alu_map u_alu_map (
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .alu_op    (map_alu_op),
        .alu_src_b (map_src),
        .illegal   (map_illegal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            halt_q  <= 1'b0;
        end else begin
            state_q <= next_state;
            halt_q  <= halt_q | (next_state == S_HALT);
        end
    end

    // Everything is forced low while RST is high so an abandoned instruction
    // cannot leave a request or write enable asserted in the reset cycle.
    always_comb begin
        next_state    = state_q;
        bus.iREN      = 1'b0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.ir_en     = 1'b0;
        bus.pc_en     = 1'b0;
        bus.pc_sel    = PC_PC4;
        bus.alu_src_b = SRC_REG;
        bus.alu_op    = ALU_ADD;
        bus.reg_wen   = 1'b0;
        bus.reg_dst   = DST_RD;
        bus.wb_sel    = WB_ALU;
        bus.halt      = halt_q & ~RST;
        bus.state     = RST ? ST_FETCH : ctrl_state_t'(state_q);
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    bus.iREN = 1'b1;
                    if (bus.ihit) begin
                        bus.ir_en  = 1'b1;
                        bus.pc_en  = 1'b1;
                        bus.pc_sel = PC_PC4;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_J: begin
                            bus.pc_en  = 1'b1;
                            bus.pc_sel = PC_JUMP;
                            next_state = S_FETCH;
                        end
                        OP_JAL: begin
                            bus.pc_en   = 1'b1;
                            bus.pc_sel  = PC_JUMP;
                            bus.reg_wen = 1'b1;
                            bus.reg_dst = DST_RA;
                            bus.wb_sel  = WB_PC4;
                            next_state  = S_FETCH;
                        end
                        OP_HALT: next_state = S_HALT;
                        default: begin
                            if (bus.opcode == OP_RTYPE && bus.funct == FN_JR) begin
                                bus.pc_en  = 1'b1;
                                bus.pc_sel = PC_JREG;
                                next_state = S_FETCH;
                            end else if (map_illegal) begin
                                next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                            end else begin
                                next_state = S_EXEC;
                            end
                        end
                    endcase
                end
                S_EXEC: begin
                    bus.alu_op    = map_alu_op;
                    bus.alu_src_b = map_src;
                    if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
                        bus.pc_en  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
                        bus.pc_sel = PC_BRANCH;
                        next_state = S_FETCH;
                    end else if (is_mem_op(bus.opcode)) begin
                        next_state = S_MEM;
                    end else begin
                        next_state = S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.opcode == OP_LW) begin
                        bus.dREN = 1'b1;
                        if (bus.dhit) next_state = S_WB;
                    end else if (bus.opcode == OP_SW) begin
                        bus.dWEN = 1'b1;
                        if (bus.dhit) next_state = S_FETCH;
                    end else begin
                        next_state = S_FETCH;
                    end
                end
                S_WB: begin
                    bus.reg_wen = 1'b1;
                    bus.reg_dst = (bus.opcode == OP_RTYPE) ? DST_RD : DST_RT;
                    if (bus.opcode == OP_LW)       bus.wb_sel = WB_MEM;
                    else if (bus.opcode == OP_LUI) bus.wb_sel = WB_LUI;
                    else                           bus.wb_sel = WB_ALU;
                    next_state = S_FETCH;
                end
                S_HALT:  next_state = S_HALT;
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed cycle-by-cycle vectors push the
// expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        iren;
        logic        dren;
        logic        dwen;
        logic        ir_en;
        logic        pc_en;
        pcsel_t      pc_sel;
        alusrc_t     alu_src_b;
        aluop_t      alu_op;
        logic        reg_wen;
        regdst_t     reg_dst;
        wbsel_t      wb_sel;
        logic        halt;
        ctrl_state_t state;
    } out_t;

    typedef struct {
        out_t  exp;
        string name;
    } sb_item_t;

    logic     CLK = 1'b0;
    logic     RST = 1'b1;
    sb_item_t sb_q[$];
    int       vectors = 0;
    int       miscompares = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic out_t base(ctrl_state_t st);
        out_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic out_t f_wait();
        out_t o;
        o = base(ST_FETCH);
        o.iren = 1'b1;
        return o;
    endfunction

    function automatic out_t f_hit();
        out_t o;
        o = f_wait();
        o.ir_en  = 1'b1;
        o.pc_en  = 1'b1;
        o.pc_sel = PC_PC4;
        return o;
    endfunction

    function automatic out_t ex(aluop_t op, alusrc_t src);
        out_t o;
        o = base(ST_EXEC);
        o.alu_op    = op;
        o.alu_src_b = src;
        return o;
    endfunction

    function automatic out_t wb(regdst_t d, wbsel_t s);
        out_t o;
        o = base(ST_WB);
        o.reg_wen = 1'b1;
        o.reg_dst = d;
        o.wb_sel  = s;
        return o;
    endfunction

    task automatic applyStimulus(input logic rst_v, input opcode_t op, input funct_t fn,
                                 input logic z, input logic ih, input logic dh,
                                 input out_t exp, input string name);
        sb_item_t it;
        @(posedge CLK);
        #1;
        RST        = rst_v;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        bus.ihit   = ih;
        bus.dhit   = dh;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic checkOutput();
        sb_item_t it;
        out_t     act;
        it = sb_q.pop_front();
        act.iren      = bus.iREN;
        act.dren      = bus.dREN;
        act.dwen      = bus.dWEN;
        act.ir_en     = bus.ir_en;
        act.pc_en     = bus.pc_en;
        act.pc_sel    = bus.pc_sel;
        act.alu_src_b = bus.alu_src_b;
        act.alu_op    = bus.alu_op;
        act.reg_wen   = bus.reg_wen;
        act.reg_dst   = bus.reg_dst;
        act.wb_sel    = bus.wb_sel;
        act.halt      = bus.halt;
        act.state     = bus.state;
        vectors++;
        if (act !== it.exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) checkOutput();
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        out_t e;
        bus.opcode = OP_RTYPE;
        bus.funct  = FN_ADDU;
        bus.zero   = 1'b0;
        bus.ihit   = 1'b0;
        bus.dhit   = 1'b0;

        // Reset hold, release, ADDU fetched on the third FETCH cycle
        applyStimulus(1, OP_RTYPE, FN_ADDU, 0, 1, 1, base(ST_FETCH), "rst_hold0");
        applyStimulus(1, OP_RTYPE, FN_ADDU, 0, 1, 0, base(ST_FETCH), "rst_hold1");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 0, f_wait(), "addu_fetch_wait0");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 1, f_wait(), "addu_fetch_wait1");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 1, 0, f_hit(), "addu_fetch_hit");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 0, base(ST_DECODE), "addu_decode");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 0, ex(ALU_ADD, SRC_REG), "addu_exec");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 0, wb(DST_RD, WB_ALU), "addu_wb");

        // LW with four wait cycles; stray ihit during MEM is ignored
        applyStimulus(0, OP_LW, FN_ADDU, 0, 1, 0, f_hit(), "lw_fetch");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, base(ST_DECODE), "lw_decode");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, ex(ALU_ADD, SRC_IMM_SEXT), "lw_exec");
        for (int i = 0; i < 4; i++) begin
            e = base(ST_MEM);
            e.dren = 1'b1;
            applyStimulus(0, OP_LW, FN_ADDU, 0, (i == 0), 0, e, "lw_mem_wait");
        end
        e = base(ST_MEM);
        e.dren = 1'b1;
        applyStimulus(0, OP_LW, FN_ADDU, 0, 1, 1, e, "lw_mem_hit");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, wb(DST_RT, WB_MEM), "lw_wb");

        // SW with the same delay, then FETCH without any register write
        applyStimulus(0, OP_SW, FN_ADDU, 0, 1, 0, f_hit(), "sw_fetch");
        applyStimulus(0, OP_SW, FN_ADDU, 0, 0, 0, base(ST_DECODE), "sw_decode");
        applyStimulus(0, OP_SW, FN_ADDU, 0, 0, 0, ex(ALU_ADD, SRC_IMM_SEXT), "sw_exec");
        for (int i = 0; i < 5; i++) begin
            e = base(ST_MEM);
            e.dwen = 1'b1;
            applyStimulus(0, OP_SW, FN_ADDU, 0, 0, (i == 4), e, "sw_mem");
        end
        applyStimulus(0, OP_SW, FN_ADDU, 0, 0, 0, f_wait(), "sw_after_fetch");

        // Branches
        applyStimulus(0, OP_BEQ, FN_ADDU, 0, 1, 0, f_hit(), "beq_fetch");
        applyStimulus(0, OP_BEQ, FN_ADDU, 1, 0, 0, base(ST_DECODE), "beq_decode");
        e = ex(ALU_SUB, SRC_REG);
        e.pc_en  = 1'b1;
        e.pc_sel = PC_BRANCH;
        applyStimulus(0, OP_BEQ, FN_ADDU, 1, 0, 0, e, "beq_taken_exec");
        applyStimulus(0, OP_BNE, FN_ADDU, 1, 1, 0, f_hit(), "bne_fetch");
        applyStimulus(0, OP_BNE, FN_ADDU, 1, 0, 0, base(ST_DECODE), "bne_decode");
        e = ex(ALU_SUB, SRC_REG);
        e.pc_sel = PC_BRANCH;
        applyStimulus(0, OP_BNE, FN_ADDU, 1, 0, 0, e, "bne_not_taken_exec");
        applyStimulus(0, OP_BEQ, FN_ADDU, 0, 1, 0, f_hit(), "beq2_fetch");
        applyStimulus(0, OP_BEQ, FN_ADDU, 0, 0, 0, base(ST_DECODE), "beq2_decode");
        applyStimulus(0, OP_BEQ, FN_ADDU, 0, 0, 0, e, "beq_not_taken_exec");

        // JAL and JR complete in DECODE
        applyStimulus(0, OP_JAL, FN_ADDU, 0, 1, 0, f_hit(), "jal_fetch");
        e = base(ST_DECODE);
        e.pc_en   = 1'b1;
        e.pc_sel  = PC_JUMP;
        e.reg_wen = 1'b1;
        e.reg_dst = DST_RA;
        e.wb_sel  = WB_PC4;
        applyStimulus(0, OP_JAL, FN_ADDU, 0, 0, 0, e, "jal_decode");
        applyStimulus(0, OP_RTYPE, FN_JR, 0, 1, 0, f_hit(), "jr_fetch");
        e = base(ST_DECODE);
        e.pc_en  = 1'b1;
        e.pc_sel = PC_JREG;
        applyStimulus(0, OP_RTYPE, FN_JR, 0, 0, 0, e, "jr_decode");

        // Zero-extended immediate and shift-amount operand selection
        applyStimulus(0, OP_ORI, FN_ADDU, 0, 1, 0, f_hit(), "ori_fetch");
        applyStimulus(0, OP_ORI, FN_ADDU, 0, 0, 0, base(ST_DECODE), "ori_decode");
        applyStimulus(0, OP_ORI, FN_ADDU, 0, 0, 0, ex(ALU_OR, SRC_IMM_ZEXT), "ori_exec");
        applyStimulus(0, OP_ORI, FN_ADDU, 0, 0, 0, wb(DST_RT, WB_ALU), "ori_wb");
        applyStimulus(0, OP_RTYPE, FN_SLL, 0, 1, 0, f_hit(), "sll_fetch");
        applyStimulus(0, OP_RTYPE, FN_SLL, 0, 0, 0, base(ST_DECODE), "sll_decode");
        applyStimulus(0, OP_RTYPE, FN_SLL, 0, 0, 0, ex(ALU_SLL, SRC_SHAMT), "sll_exec");
        applyStimulus(0, OP_RTYPE, FN_SLL, 0, 0, 0, wb(DST_RD, WB_ALU), "sll_wb");
        applyStimulus(0, OP_LUI, FN_ADDU, 0, 1, 0, f_hit(), "lui_fetch");
        applyStimulus(0, OP_LUI, FN_ADDU, 0, 0, 0, base(ST_DECODE), "lui_decode");
        applyStimulus(0, OP_LUI, FN_ADDU, 0, 0, 0, ex(ALU_OR, SRC_IMM_ZEXT), "lui_exec");
        applyStimulus(0, OP_LUI, FN_ADDU, 0, 0, 0, wb(DST_RT, WB_LUI), "lui_wb");

        // Illegal opcode retires as a NOP
        applyStimulus(0, opcode_t'(6'h3E), FN_ADDU, 0, 1, 0, f_hit(), "illegal_fetch");
        applyStimulus(0, opcode_t'(6'h3E), FN_ADDU, 0, 0, 0, base(ST_DECODE), "illegal_decode");
        applyStimulus(0, opcode_t'(6'h3E), FN_ADDU, 0, 0, 0, f_wait(), "illegal_back_fetch");

        // Reset during a LW memory wait
        applyStimulus(0, OP_LW, FN_ADDU, 0, 1, 0, f_hit(), "lwr_fetch");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, base(ST_DECODE), "lwr_decode");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, ex(ALU_ADD, SRC_IMM_SEXT), "lwr_exec");
        e = base(ST_MEM);
        e.dren = 1'b1;
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, e, "lwr_mem_wait0");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, e, "lwr_mem_wait1");
        applyStimulus(1, OP_LW, FN_ADDU, 0, 0, 0, base(ST_FETCH), "lwr_reset_cycle");
        applyStimulus(0, OP_LW, FN_ADDU, 0, 0, 0, f_wait(), "lwr_after_reset");

        // HALT is sticky and ignores strobes and opcode changes until reset
        applyStimulus(0, OP_HALT, FN_ADDU, 0, 1, 0, f_hit(), "halt_fetch");
        applyStimulus(0, OP_HALT, FN_ADDU, 0, 0, 0, base(ST_DECODE), "halt_decode");
        for (int i = 0; i < 20; i++) begin
            e = base(ST_HALT);
            e.halt = 1'b1;
            applyStimulus(0, (i % 2 == 1) ? OP_LW : OP_HALT, FN_ADDU, 0,
                          logic'(i % 2), logic'((i + 1) % 2), e, "halt_hold");
        end
        applyStimulus(1, OP_RTYPE, FN_ADDU, 0, 1, 1, base(ST_FETCH), "halt_reset_cycle");
        applyStimulus(0, OP_RTYPE, FN_ADDU, 0, 0, 0, f_wait(), "halt_after_reset");

        @(negedge CLK);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
